// File: rtl/dtw_axil_regs_if.sv
// AXI4-Lite slave bus bundle for the DTW register block.
// Signal names follow the AXI S_AXI_* naming used by the rest of the DTW core.
// slave  : the register block side
// master : the bus-driving side (interconnect or testbench)
interface dtw_axil_regs_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic [2:0]          S_AXI_AWPROT;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic [2:0]          S_AXI_ARPROT;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

// File: rtl/dtw_axil_regs.sv
// AXI4-Lite register file for the DTW core: four 32-bit registers at byte
// offsets 0x0/0x4/0x8/0xC, independent write and read state machines, a
// one-cycle write strobe per register towards the core.
// Build option: define DTW_AXIL_WSTRB_EN to honour WSTRB per byte lane;
// without it every write replaces the full 32-bit word.
module dtw_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   dtw_axil_regs_if.slave                s_axi,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
   output logic [3:0]                    reg_wr_pulse_o
);
   localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;
   localparam int IDX_LSB   = 2;

   typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;
   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   // write channel state
   wstate_t                wstate_q;
   logic                   awready_q;
   logic                   wready_q;
   logic                   bvalid_q;
   logic [1:0]             waddr_q;
   word_t                  wdata_q;
   logic [NUM_LANES-1:0]   wstrb_q;

   // read channel state
   rstate_t                rstate_q;
   logic                   arready_q;
   logic                   rvalid_q;
   word_t                  rdata_q;

   // register storage and write strobe
   word_t                  regs_q [4];
   logic [3:0]             pulse_q;

   logic                   aw_hs;
   logic                   w_hs;
   logic                   b_hs;
   logic                   ar_hs;
   logic                   r_hs;
   logic [1:0]             aw_idx;
   logic [1:0]             ar_idx;

   // write that completes on the coming edge, with its merged word
   logic                   wr_en_d;
   logic [1:0]             wr_idx_d;
   word_t                  wr_data_d;
   logic [NUM_LANES-1:0]   wr_strb_d;
   logic [NUM_LANES-1:0]   lane_en_d;
   word_t                  wr_word_d;

   // Handshakes are taken against the registered ready/valid outputs.
   assign aw_hs  = s_axi.S_AXI_AWVALID & awready_q;
   assign w_hs   = s_axi.S_AXI_WVALID  & wready_q;
   assign b_hs   = bvalid_q & s_axi.S_AXI_BREADY;
   assign ar_hs  = s_axi.S_AXI_ARVALID & arready_q;
   assign r_hs   = rvalid_q & s_axi.S_AXI_RREADY;
   assign aw_idx = s_axi.S_AXI_AWADDR[IDX_LSB +: 2];
   assign ar_idx = s_axi.S_AXI_ARADDR[IDX_LSB +: 2];

   // Pick address/data/strobe for the write completing this cycle: the half
   // that arrived earlier comes from the latch, the other half from the bus.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_idx_d  = aw_idx;
      wr_data_d = s_axi.S_AXI_WDATA;
      wr_strb_d = s_axi.S_AXI_WSTRB;
      case (wstate_q)
         W_IDLE:      wr_en_d = aw_hs & w_hs;
         W_HAVE_ADDR: begin
            wr_en_d  = w_hs;
            wr_idx_d = waddr_q;
         end
         W_HAVE_DATA: begin
            wr_en_d   = aw_hs;
            wr_data_d = wdata_q;
            wr_strb_d = wstrb_q;
         end
         default:     wr_en_d = 1'b0;
      endcase
   end

   // Per byte lane: take new data where enabled, keep the old byte otherwise.
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
`ifdef DTW_AXIL_WSTRB_EN
      assign lane_en_d[gi] = wr_strb_d[gi];
`else
      assign lane_en_d[gi] = 1'b1;
`endif
      assign wr_word_d[gi*8 +: 8] = lane_en_d[gi] ? wr_data_d[gi*8 +: 8]
                                                  : regs_q[wr_idx_d][gi*8 +: 8];
   end

   // Write channel FSM: collects AW and W in either order, then holds the
   // OKAY response until the master takes it (one write outstanding).
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (aw_hs && w_hs) begin
                  wstate_q  <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
               end else if (aw_hs) begin
                  wstate_q  <= W_HAVE_ADDR;
                  waddr_q   <= aw_idx;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
               end else if (w_hs) begin
                  wstate_q  <= W_HAVE_DATA;
                  wdata_q   <= s_axi.S_AXI_WDATA;
                  wstrb_q   <= s_axi.S_AXI_WSTRB;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b0;
               end else begin
                  // also raises the readies on the first edge after reset
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_HAVE_ADDR: begin
               if (w_hs) begin
                  wstate_q  <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
               end
            end
            W_HAVE_DATA: begin
               if (aw_hs) begin
                  wstate_q  <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
               end
            end
            W_RESP: begin
               if (b_hs) begin
                  wstate_q  <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: begin
               wstate_q  <= W_IDLE;
               awready_q <= 1'b0;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b0;
            end
         endcase
      end
   end

   // Register update and the one-cycle strobe that follows each write.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
         pulse_q <= '0;
      end else begin
         pulse_q <= '0;
         if (wr_en_d) begin
            regs_q[wr_idx_d]  <= wr_word_d;
            pulse_q[wr_idx_d] <= 1'b1;
         end
      end
   end

   // Read channel FSM: captures the addressed register on the AR edge (so a
   // same-edge write is not visible) and holds it until RREADY.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rstate_q  <= R_DATA;
                  rdata_q   <= regs_q[ar_idx];
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (r_hs) begin
                  rstate_q  <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: begin
               rstate_q  <= R_IDLE;
               arready_q <= 1'b0;
               rvalid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RRESP   = 2'b00;
   assign s_axi.S_AXI_RDATA   = rdata_q;

   assign reg0_o         = regs_q[0];
   assign reg1_o         = regs_q[1];
   assign reg2_o         = regs_q[2];
   assign reg3_o         = regs_q[3];
   assign reg_wr_pulse_o = pulse_q;

   // PROT, sub-word address bits and (in the full-word build) WSTRB carry
   // no meaning for this block.
   logic unused_ok;
   assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR, wr_strb_d};
endmodule

// File: tb/tb_dtw_axil_regs.sv
// Directed + randomized bench for dtw_axil_regs against an array model of
// the four registers. Honours DTW_AXIL_WSTRB_EN the same way as the design.
module tb_dtw_axil_regs;
   logic        clk;
   logic        rst_n;
   logic [31:0] r0, r1, r2, r3;
   logic [3:0]  pulse;

   int          tests_run;
   int          tests_failed;
   logic [31:0] model_regs [4];

   dtw_axil_regs_if #(.DATA_W(32), .ADDR_W(4)) bus ();

   dtw_axil_regs #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .s_axi         (bus),
      .reg0_o        (r0),
      .reg1_o        (r1),
      .reg2_o        (r2),
      .reg3_o        (r3),
      .reg_wr_pulse_o(pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dut_reg(input int i);
      case (i)
         0:       return r0;
         1:       return r1;
         2:       return r2;
         default: return r3;
      endcase
   endfunction

   // Byte-lane write rule: lanes with strobe set take new data.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] mask;
`ifdef DTW_AXIL_WSTRB_EN
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`else
      mask = 32'hFFFF_FFFF;
`endif
      return (old & ~mask) | (d & mask);
   endfunction

   // Full write: AW and W offered after independent delays, B accepted after b_dly.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
      int cyc;
      bit aw_done, w_done, aw_fire, w_fire;
      int idx;
      cyc = 0; aw_done = 0; w_done = 0;
      idx = int'(addr[3:2]);
      bus.S_AXI_BREADY = 1'b0;
      while (!(aw_done && w_done) && cyc < 50) begin
         if (!aw_done && cyc >= aw_dly) begin
            bus.S_AXI_AWADDR  = addr;
            bus.S_AXI_AWPROT  = 3'($urandom);
            bus.S_AXI_AWVALID = 1'b1;
         end
         if (!w_done && cyc >= w_dly) begin
            bus.S_AXI_WDATA  = data;
            bus.S_AXI_WSTRB  = strb;
            bus.S_AXI_WVALID = 1'b1;
         end
         aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         chk("bvalid_early", {31'd0, bus.S_AXI_BVALID}, 32'd0);
         tick();
         cyc++;
         if (aw_fire) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
         if (w_fire)  begin w_done = 1;  bus.S_AXI_WVALID  = 1'b0; end
      end
      chk("wr_handshake_timeout", {31'd0, aw_done && w_done}, 32'd1);
      model_regs[idx] = merge(model_regs[idx], data, strb);
      chk("bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
      chk("bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
      chk("wr_pulse", {28'd0, pulse}, 32'd1 << idx);
      chk("reg_o", dut_reg(idx), model_regs[idx]);
      for (int k = 0; k < b_dly; k++) begin
         tick();
         chk("bvalid_hold", {31'd0, bus.S_AXI_BVALID}, 32'd1);
         chk("awready_hold", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
         chk("wr_pulse_once", {28'd0, pulse}, 32'd0);
      end
      bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_BREADY = 1'b0;
      chk("bvalid_clr", {31'd0, bus.S_AXI_BVALID}, 32'd0);
   endtask

   // Full read: AR after ar_dly, RREADY held low r_dly cycles after RVALID.
   task automatic axi_read(input logic [3:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data);
      int cyc;
      bit done, fire;
      cyc = 0; done = 0;
      bus.S_AXI_RREADY = 1'b0;
      while (!done && cyc < 50) begin
         if (cyc >= ar_dly) begin
            bus.S_AXI_ARADDR  = addr;
            bus.S_AXI_ARPROT  = 3'($urandom);
            bus.S_AXI_ARVALID = 1'b1;
         end
         fire = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
         tick();
         cyc++;
         if (fire) begin done = 1; bus.S_AXI_ARVALID = 1'b0; end
      end
      chk("ar_handshake_timeout", {31'd0, done}, 32'd1);
      chk("rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
      chk("rresp", {30'd0, bus.S_AXI_RRESP}, 32'd0);
      data = bus.S_AXI_RDATA;
      for (int k = 0; k < r_dly; k++) begin
         tick();
         chk("rdata_stable", bus.S_AXI_RDATA, data);
         chk("rvalid_hold", {31'd0, bus.S_AXI_RVALID}, 32'd1);
      end
      bus.S_AXI_RREADY = 1'b1;
      tick();
      bus.S_AXI_RREADY = 1'b0;
      chk("rvalid_clr", {31'd0, bus.S_AXI_RVALID}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp31;
      logic [3:0]  a;
      tests_run = 0;
      tests_failed = 0;
      for (int i = 0; i < 4; i++) model_regs[i] = 32'd0;
      rst_n = 1'b0;
      bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;

      // ---- reset state
      repeat (3) tick();
      chk("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
      chk("rst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
      chk("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
      chk("rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
      chk("rst_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd0);
      chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
      chk("rst_resp", {28'd0, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 32'd0);
      chk("rst_pulse", {28'd0, pulse}, 32'd0);
      for (int i = 0; i < 4; i++) chk("rst_reg", dut_reg(i), 32'd0);
      rst_n = 1'b1;
      chk("ready_after_release_noedge", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
      tick();
      chk("awready_up", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
      chk("wready_up", {31'd0, bus.S_AXI_WREADY}, 32'd1);
      chk("arready_up", {31'd0, bus.S_AXI_ARREADY}, 32'd1);

      // ---- four writes then read-back
      for (int i = 0; i < 4; i++)
         axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4 * i), 0, 0, rd);
         chk("readback_const", rd, 32'(i + 1));
      end

      // ---- W leads AW by three cycles
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      tick();
      bus.S_AXI_WVALID = 1'b0;
      tick();
      chk("wfirst_no_b", {31'd0, bus.S_AXI_BVALID}, 32'd0);
      chk("wfirst_wready_low", {31'd0, bus.S_AXI_WREADY}, 32'd0);
      tick();
      chk("wfirst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
      bus.S_AXI_AWADDR = 4'h8; bus.S_AXI_AWVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      model_regs[2] = merge(model_regs[2], 32'hDEADBEEF, 4'hF);
      chk("wfirst_reg2", r2, 32'hDEADBEEF);
      chk("wfirst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
      chk("wfirst_pulse", {28'd0, pulse}, 32'h4);
      bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_BREADY = 1'b0;
      chk("wfirst_pulse_one_cycle", {28'd0, pulse}, 32'd0);
      chk("wfirst_single_b", {31'd0, bus.S_AXI_BVALID}, 32'd0);

      // ---- BREADY held low; a second write waits for the B handshake
      bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'h0BAD_F00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      tick();
      model_regs[3] = merge(model_regs[3], 32'h0BAD_F00D, 4'hF);
      bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_WDATA = 32'h7777_1111;
      for (int k = 0; k < 5; k++) begin
         chk("bhold_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
         chk("bhold_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
         chk("bhold_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
         chk("bhold_reg0", r0, model_regs[0]);
         tick();
      end
      chk("bhold_reg3", r3, model_regs[3]);
      bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_BREADY = 1'b0;
      chk("bhold_released", {31'd0, bus.S_AXI_BVALID}, 32'd0);
      chk("bhold_reg0_still", r0, model_regs[0]);
      tick();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      model_regs[0] = merge(model_regs[0], 32'h7777_1111, 4'hF);
      chk("second_wr_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
      chk("second_wr_reg0", r0, model_regs[0]);
      bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_BREADY = 1'b0;

      // ---- partial strobe
      axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      axi_write(4'h4, 32'h1234_5678, 4'b0011, 1, 0, 0);
`ifdef DTW_AXIL_WSTRB_EN
      exp31 = 32'hFFFF_5678;
`else
      exp31 = 32'h1234_5678;
`endif
      chk("strb_reg1", r1, exp31);
      axi_read(4'h4, 0, 0, rd);
      chk("strb_read", rd, exp31);

      // ---- reset while holding an address
      axi_write(4'h0, 32'h55, 4'hF, 0, 0, 0);
      bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_reg0", r0, 32'd0);
      chk("midrst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
      for (int i = 0; i < 4; i++) model_regs[i] = 32'd0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("midrst_no_b", {31'd0, bus.S_AXI_BVALID}, 32'd0);
      end
      axi_read(4'h0, 0, 0, rd);
      chk("midrst_read0", rd, 32'd0);

      // ---- same-edge write and read of reg1
      axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0);
      chk("same_edge_ready", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd7);
      bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'hA5A5_A5A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_ARADDR = 4'h4; bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
      chk("same_edge_rdata_old", bus.S_AXI_RDATA, model_regs[1]);
      model_regs[1] = merge(model_regs[1], 32'hA5A5_A5A5, 4'hF);
      chk("same_edge_reg1_new", r1, model_regs[1]);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("same_edge_rdata_stable", bus.S_AXI_RDATA, 32'h2);
         chk("same_edge_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
      end
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_RREADY = 1'b1;
      tick();
      bus.S_AXI_RREADY = 1'b0;
      chk("same_edge_rvalid_clr", {31'd0, bus.S_AXI_RVALID}, 32'd0);
      axi_read(4'h4, 0, 0, rd);
      chk("same_edge_reread", rd, 32'hA5A5_A5A5);

      // ---- randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) begin
            axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         end else begin
            axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), rd);
            chk("rand_read", rd, model_regs[a[3:2]]);
         end
      end
      for (int i = 0; i < 4; i++) chk("final_reg", dut_reg(i), model_regs[i]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
